// File: rtl/t07_wb_arb_pkg.sv
// Shared types and constants for the team_07 Wishbone arbiter.
package t07_wb_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } wb_arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } wb_arb_grant_t;

    // Returned on reads that never see the manager finish.
    localparam logic [31:0] POISON_WORD         = 32'hDEADBEEF;
    localparam logic [7:0]  DEFAULT_ADDR_PREFIX = 8'h33;

    // External address: fixed upper byte, low 24 bits from the requester.
    function automatic logic [31:0] form_addr(input logic [7:0]  prefix,
                                              input logic [31:0] addr);
        return {prefix, addr[23:0]};
    endfunction

endpackage

// File: rtl/t07_wb_arbiter_if.sv
// Bundle of the CPU-side request ports and the Wishbone-manager-side ports.
// master: the arbiter itself. slave: the CPU handlers plus the manager.
interface t07_wb_arbiter_if;

    logic        f_req_i;
    logic [31:0] f_addr_i;
    logic        f_ack_o;
    logic [31:0] f_rdata_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_sel_i;
    logic        d_ack_o;
    logic [31:0] d_rdata_o;

    logic        err_o;

    logic [31:0] WBData_i;
    logic        WB_busy_i;
    logic        WB_read_o;
    logic        WB_write_o;
    logic [31:0] addr_out;
    logic [31:0] WBData_out;
    logic [3:0]  WB_sel_o;

    modport master (
        input  f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
        input  WBData_i, WB_busy_i,
        output f_ack_o, f_rdata_o, d_ack_o, d_rdata_o, err_o,
        output WB_read_o, WB_write_o, addr_out, WBData_out, WB_sel_o
    );

    modport slave (
        output f_req_i, f_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i, d_sel_i,
        output WBData_i, WB_busy_i,
        input  f_ack_o, f_rdata_o, d_ack_o, d_rdata_o, err_o,
        input  WB_read_o, WB_write_o, addr_out, WBData_out, WB_sel_o
    );

endinterface

// File: rtl/t07_wb_timeout.sv
// Saturating WAIT-cycle counter; tc_o flags the enabled cycle that reaches TIMEOUT.
module t07_wb_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stop at TIMEOUT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = en_i && (cnt_q >= CntLast);

endmodule

// File: rtl/t07_wb_arbiter.sv
// Round-robin fetch/data arbiter sequencing one Wishbone manager transaction at a time.
module t07_wb_arbiter
    import t07_wb_arb_pkg::*;
#(
    parameter logic [7:0]  ADDR_PREFIX = DEFAULT_ADDR_PREFIX,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic               clk,
    input logic               rst,
    t07_wb_arbiter_if.master  bus_io
);

    wb_arb_state_t state_q, state_d;
    wb_arb_grant_t grant_q, grant_d;
    wb_arb_grant_t last_grant_q, last_grant_d;
    wb_arb_grant_t pick;

    logic        seen_busy_q, seen_busy_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        f_ack_q, f_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;
    logic [31:0] f_rdata_q, f_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic cnt_clr, cnt_en, cnt_tc;

    t07_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // Round-robin pick; only meaningful while a request is pending in IDLE.
    always_comb begin
        if (bus_io.f_req_i && bus_io.d_req_i) begin
            pick = (last_grant_q == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA;
        end else if (bus_io.f_req_i) begin
            pick = GRANT_FETCH;
        end else begin
            pick = GRANT_DATA;
        end
    end

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        seen_busy_d  = seen_busy_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        we_d         = we_q;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        f_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        f_rdata_d    = f_rdata_q;
        d_rdata_d    = d_rdata_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus_io.f_req_i || bus_io.d_req_i) begin
                    grant_d = pick;
                    if (pick == GRANT_FETCH) begin
                        addr_d  = form_addr(ADDR_PREFIX, bus_io.f_addr_i);
                        wdata_d = '0;
                        sel_d   = 4'hF;
                        we_d    = 1'b0;
                        rd_d    = 1'b1;
                    end else begin
                        addr_d  = form_addr(ADDR_PREFIX, bus_io.d_addr_i);
                        wdata_d = bus_io.d_wdata_i;
                        sel_d   = bus_io.d_sel_i;
                        we_d    = bus_io.d_we_i;
                        rd_d    = !bus_io.d_we_i;
                        wr_d    = bus_io.d_we_i;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                seen_busy_d = 1'b0;
                cnt_clr     = 1'b1;
                state_d     = StWait;
            end
            StWait: begin
                if (bus_io.WB_busy_i) begin
                    seen_busy_d = 1'b1;
                end
                if (seen_busy_q && !bus_io.WB_busy_i) begin
                    if (!we_q) begin
                        if (grant_q == GRANT_FETCH) f_rdata_d = bus_io.WBData_i;
                        else                        d_rdata_d = bus_io.WBData_i;
                    end
                    f_ack_d = (grant_q == GRANT_FETCH);
                    d_ack_d = (grant_q == GRANT_DATA);
                    state_d = StDone;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_tc) begin
                        if (!we_q) begin
                            if (grant_q == GRANT_FETCH) f_rdata_d = POISON_WORD;
                            else                        d_rdata_d = POISON_WORD;
                        end
                        err_d   = 1'b1;
                        f_ack_d = (grant_q == GRANT_FETCH);
                        d_ack_d = (grant_q == GRANT_DATA);
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Requests are deliberately ignored here so a requester
                // dropping req on its ack cycle is not served twice.
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; synchronous reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= GRANT_DATA;
            last_grant_q <= GRANT_DATA;
            seen_busy_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            f_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            seen_busy_q  <= seen_busy_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            f_ack_q      <= f_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus_io.f_ack_o    = f_ack_q;
    assign bus_io.f_rdata_o  = f_rdata_q;
    assign bus_io.d_ack_o    = d_ack_q;
    assign bus_io.d_rdata_o  = d_rdata_q;
    assign bus_io.err_o      = err_q;
    assign bus_io.WB_read_o  = rd_q;
    assign bus_io.WB_write_o = wr_q;
    assign bus_io.addr_out   = addr_q;
    assign bus_io.WBData_out = wdata_q;
    assign bus_io.WB_sel_o   = sel_q;

endmodule

// File: tb/tb_t07_wb_arbiter.sv
// Self-checking bench: vector table plus scoreboard queue checked on every ack.
module tb_t07_wb_arbiter;

    localparam int unsigned Tmo = 8;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          len;     // manager busy cycles; 0 = busy never rises
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        bit          err;
        int          lat;     // cycles from strobe to ack
    } exp_t;

    typedef struct {
        int          len;
        logic [31:0] data;
    } mgr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    t07_wb_arbiter_if bus ();

    t07_wb_arbiter #(
        .ADDR_PREFIX (8'h33),
        .TIMEOUT     (Tmo)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    exp_t        sb_q[$];
    mgr_t        mgr_q[$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] f_model = '0;
    logic [31:0] d_model = '0;
    vec_t        vecs[8];

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input bit is_data, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] sel,
                                input int len, input logic [31:0] rdata);
        vec_t v;
        v.is_data = is_data; v.we = we; v.addr = addr; v.wdata = wdata;
        v.sel = sel; v.len = len; v.rdata = rdata;
        return v;
    endfunction

    function automatic void push_txn(input vec_t v);
        exp_t e;
        mgr_t m;
        e.is_data = v.is_data;
        e.we      = v.we;
        e.addr    = {8'h33, v.addr[23:0]};
        e.wdata   = v.wdata;
        e.sel     = v.is_data ? v.sel : 4'hF;
        e.err     = (v.len == 0);
        e.rdata   = (v.len == 0) ? 32'hDEADBEEF : v.rdata;
        e.lat     = (v.len == 0) ? int'(Tmo) + 1 : v.len + 2;
        sb_q.push_back(e);
        m.len  = v.len;
        m.data = v.rdata;
        mgr_q.push_back(m);
    endfunction

    task automatic drive_req(input vec_t v);
        if (v.is_data) begin
            bus.d_we_i    = v.we;
            bus.d_addr_i  = v.addr;
            bus.d_wdata_i = v.wdata;
            bus.d_sel_i   = v.sel;
            bus.d_req_i   = 1'b1;
        end else begin
            bus.f_addr_i  = v.addr;
            bus.f_req_i   = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit is_data, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            if (is_data ? bus.d_ack_o : bus.f_ack_o) got = 1'b1;
        end
        chk(name, {31'b0, got}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        push_txn(v);
        drive_req(v);
        wait_ack(v.is_data, "ack_wait");
        if (v.is_data) bus.d_req_i = 1'b0;
        else           bus.f_req_i = 1'b0;
    endtask

    task automatic chk_zero();
        chk("rst_f_ack",   {31'b0, bus.f_ack_o},    32'd0);
        chk("rst_d_ack",   {31'b0, bus.d_ack_o},    32'd0);
        chk("rst_err",     {31'b0, bus.err_o},      32'd0);
        chk("rst_rd",      {31'b0, bus.WB_read_o},  32'd0);
        chk("rst_wr",      {31'b0, bus.WB_write_o}, 32'd0);
        chk("rst_f_rdata", bus.f_rdata_o,           32'd0);
        chk("rst_d_rdata", bus.d_rdata_o,           32'd0);
        chk("rst_addr",    bus.addr_out,            32'd0);
        chk("rst_wdata",   bus.WBData_out,          32'd0);
        chk("rst_sel",     {28'b0, bus.WB_sel_o},   32'd0);
    endtask

    // Wishbone manager model: busy rises the cycle after the strobe for len cycles.
    initial begin
        mgr_t m;
        bit   aborted;
        bus.WB_busy_i = 1'b0;
        bus.WBData_i  = 32'h0BAD_0BAD;
        forever begin
            @(posedge clk); #1;
            if (!rst && (bus.WB_read_o || bus.WB_write_o)) begin
                if (mgr_q.size() == 0) begin
                    chk("mgr_underflow", 32'd0, 32'd1);
                end else begin
                    m = mgr_q.pop_front();
                    if (m.len > 0) begin
                        @(posedge clk); #1;
                        bus.WB_busy_i = 1'b1;
                        bus.WBData_i  = ~m.data;
                        aborted = 1'b0;
                        for (int i = 0; i < m.len; i++) begin
                            @(posedge clk); #1;
                            if (rst) begin
                                aborted = 1'b1;
                                break;
                            end
                        end
                        bus.WB_busy_i = 1'b0;
                        if (!aborted) bus.WBData_i = m.data;
                    end
                end
            end
        end
    end

    // Monitor: record each strobe, check each ack against the scoreboard head.
    initial begin
        int          cyc = 0;
        int          st_cyc = 0;
        int          n_strobe = 0;
        logic [31:0] st_addr = '0;
        logic [31:0] st_wdata = '0;
        logic [3:0]  st_sel = '0;
        logic        st_we = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                n_strobe = 0;
            end else begin
                if (bus.WB_read_o || bus.WB_write_o) begin
                    chk("strobe_excl", {31'b0, bus.WB_read_o & bus.WB_write_o}, 32'd0);
                    n_strobe++;
                    st_cyc   = cyc;
                    st_we    = bus.WB_write_o;
                    st_addr  = bus.addr_out;
                    st_wdata = bus.WBData_out;
                    st_sel   = bus.WB_sel_o;
                end
                if (bus.f_ack_o || bus.d_ack_o) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", {31'b0, bus.f_ack_o | bus.d_ack_o}, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("ack_both", {31'b0, bus.f_ack_o & bus.d_ack_o}, 32'd0);
                        chk("ack_port", {31'b0, bus.d_ack_o}, {31'b0, e.is_data});
                        chk("err", {31'b0, bus.err_o}, {31'b0, e.err});
                        chk("strobe_cnt", n_strobe, 32'd1);
                        chk("strobe_dir", {31'b0, st_we}, {31'b0, e.we});
                        chk("addr", st_addr, e.addr);
                        chk("addr_hold", bus.addr_out, st_addr);
                        chk("sel", {28'b0, st_sel}, {28'b0, e.sel});
                        chk("sel_hold", {28'b0, bus.WB_sel_o}, {28'b0, st_sel});
                        if (e.we) chk("wdata", st_wdata, e.wdata);
                        chk("latency", cyc - st_cyc, e.lat);
                        if (!e.we) begin
                            if (e.is_data) d_model = e.rdata;
                            else           f_model = e.rdata;
                        end
                        chk("f_rdata", bus.f_rdata_o, f_model);
                        chk("d_rdata", bus.d_rdata_o, d_model);
                    end
                    n_strobe = 0;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int gap;

        bus.f_req_i = 1'b0; bus.f_addr_i = '0;
        bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_addr_i = '0;
        bus.d_wdata_i = '0; bus.d_sel_i = '0;

        vecs[0] = mk(1'b0, 1'b0, 32'h0000_0040, 32'h0,          4'hF, 3, 32'h0010_0093);
        vecs[1] = mk(1'b1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'h3, 2, 32'h5555_5555);
        vecs[2] = mk(1'b1, 1'b0, 32'h1234_5678, 32'h0,          4'hF, 1, 32'hA5A5_0001);
        vecs[3] = mk(1'b1, 1'b0, 32'h0000_0100, 32'h0,          4'hF, 0, 32'h7777_7777);
        vecs[4] = mk(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,          4'hF, 7, 32'h0000_0001);
        vecs[5] = mk(1'b1, 1'b1, 32'h00AB_CDE0, 32'h0102_0304, 4'h0, 0, 32'h0);
        vecs[6] = mk(1'b0, 1'b0, 32'h0000_1000, 32'h0,          4'hF, 1, 32'hF00D_0006);
        vecs[7] = mk(1'b1, 1'b0, 32'h0000_0404, 32'h0,          4'hC, 2, 32'h8421_0007);

        repeat (3) @(posedge clk);
        #1;
        chk_zero();
        rst = 1'b0;

        // Both requests from reset, held across four transactions.
        push_txn(mk(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 32'h1111_0001));
        push_txn(mk(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h5, 2, 32'h2222_0002));
        push_txn(mk(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 32'h1111_0003));
        push_txn(mk(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h5, 3, 32'h2222_0004));
        drive_req(mk(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h0));
        drive_req(mk(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h5, 0, 32'h0));
        acks = 0;
        for (int i = 0; i < 200 && acks < 4; i++) begin
            @(posedge clk); #1;
            if (bus.f_ack_o || bus.d_ack_o) acks++;
        end
        bus.f_req_i = 1'b0;
        bus.d_req_i = 1'b0;
        chk("alt_acks", acks, 32'd4);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Fetch drops req mid-WAIT; pending data request follows right after DONE.
        push_txn(mk(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 4, 32'h3333_0001));
        push_txn(mk(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'h1, 1, 32'h4444_0002));
        drive_req(mk(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'hF, 0, 32'h0));
        drive_req(mk(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'h1, 0, 32'h0));
        repeat (4) @(posedge clk);
        #1;
        bus.f_req_i = 1'b0;
        wait_ack(1'b0, "drop_f_ack");
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            gap++;
            if (bus.WB_read_o || bus.WB_write_o) break;
        end
        chk("regrant_gap", gap, 32'd2);
        wait_ack(1'b1, "drop_d_ack");
        bus.d_req_i = 1'b0;

        // Reset during WAIT abandons the load with no ack.
        push_txn(mk(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF, 6, 32'h9999_0001));
        drive_req(mk(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'hF, 0, 32'h0));
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.d_req_i = 1'b0;
        @(posedge clk); #1;
        chk_zero();
        sb_q.delete();
        f_model = '0;
        d_model = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        run_vec(mk(1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'hF, 2, 32'h0020_0113));
        repeat (3) @(posedge clk);
        #1;

        chk("sb_empty",  sb_q.size(),  32'd0);
        chk("mgr_empty", mgr_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/t07_wb_arbiter.md
# t07_wb_arbiter

Two-port arbiter and sequencer for the single Wishbone manager in the team_07 SoC. It shares the manager between the CPU instruction-fetch port and the data load/store port. It runs one transaction at a time through a fixed issue/wait/done sequence and forms the `0x33`-prefixed external address. It also recovers from a hung manager with a timeout that returns the `0xDEADBEEF` poison word. It sits between the CPU fetch/memory handlers and the Wishbone manager, replacing the ad-hoc read/write strobe logic in the MMIO path.

## Interface
Parameters:
- `ADDR_PREFIX`, default `8'h33`: upper byte placed on every outgoing address.
- `TIMEOUT`, default `255`: maximum cycles spent in WAIT before the transaction is aborted. Legal range 1..65535.

Ports (all outputs registered):
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `f_req_i`  in  1  fetch request; held high until `f_ack_o`.
- `f_addr_i`  in  32  fetch address.
- `f_ack_o`  out  1  one-cycle fetch completion pulse.
- `f_rdata_o`  out  32  fetched word; valid while `f_ack_o`=1 and held until the next fetch completion.
- `d_req_i`  in  1  data request; held until `d_ack_o`.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_addr_i`  in  32  data address.
- `d_wdata_i`  in  32  store data.
- `d_sel_i`  in  4  byte enables.
- `d_ack_o`  out  1  one-cycle data completion pulse.
- `d_rdata_o`  out  32  load data; same validity rules as `f_rdata_o`.
- `err_o`  out  1  one-cycle pulse, coincident with the ack, when the transaction timed out.
- `WBData_i`  in  32  read data from the manager.
- `WB_busy_i`  in  1  manager busy.
- `WB_read_o`, `WB_write_o`  out  1 each  one-cycle transaction strobes.
- `addr_out`  out  32  `{ADDR_PREFIX, addr[23:0]}`.
- `WBData_out`  out  32  store data.
- `WB_sel_o`  out  4  byte enables; `4'hF` for fetches.

## Operation
States:
- **IDLE**
  - No request pending: stay.
  - Only one request pending: grant it.
  - Both pending: grant the port not granted last time (round-robin). `last_grant` resets to data, so the first tie goes to fetch.
  - On grant: latch address, write data, sel and direction into the output registers. Next state ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Strobe high: `WB_read_o` for a fetch or load, `WB_write_o` for a store.
  - Clear `seen_busy`, clear the timeout counter. Next state WAIT.
- **WAIT**
  - Strobes low.
  - `WB_busy_i`=1 sets `seen_busy`.
  - `seen_busy`=1 and `WB_busy_i`=0: capture `WBData_i` into the granted port's rdata register (loads and fetches only). Next state DONE.
  - Otherwise the counter increments. On reaching `TIMEOUT`: load `32'hDEADBEEF` into rdata (reads), set the error flag. Next state DONE.
- **DONE** (exactly 1 cycle)
  - Granted port's ack = 1; `err_o` = error flag.
  - Update `last_grant`. Next state IDLE.
  - Requests are not sampled in DONE, so a requester dropping `req` on the ack cycle is never double-served.

Rules:
- Stores leave both rdata registers unchanged.
- A requester that drops `req` before its ack does not cancel the transaction; it still completes and acks.
- The non-granted port's request stays pending and wins the next arbitration if it is still high.
- `addr_out`, `WBData_out` and `WB_sel_o` stay stable from ISSUE through DONE.
- Counter width is `$clog2(TIMEOUT+1)`. No wrap is possible: the counter stops at `TIMEOUT`.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant` = data, counter 0, `seen_busy` 0.
- Reset asserted mid-transaction: the transaction is abandoned and no ack is generated. The manager is expected to be reset on the same `rst`.
- Cycle sequence for a request seen in IDLE at cycle 0:
  - cycle 1: strobe.
  - cycle 2 onward: WAIT.
  - busy observed falling at cycle k: rdata written at the k edge, ack high in cycle k+1.
- Minimum latency, request to ack, is 4 cycles (busy high for one cycle, at cycle 2).
- Back-to-back: the next grant can occur in the cycle after DONE, so throughput is one transaction per 4+busy cycles.
- Busy that never rises: timeout fires after `TIMEOUT` WAIT cycles.

## Structure
- Package `t07_wb_arb_pkg` holds:
  - state enum `wb_arb_state_t` (IDLE, ISSUE, WAIT, DONE),
  - grant enum (`GRANT_FETCH`, `GRANT_DATA`),
  - `POISON_WORD = 32'hDEADBEEF`,
  - default `ADDR_PREFIX`.
- One sub-module: `t07_wb_timeout`, a saturating counter with clear, enable and terminal-count output, parameterised by `TIMEOUT`.

## Test plan
- Fetch only, `f_addr_i`=`0x0000_0040`, busy high for cycles 2–4 with `WBData_i`=`0x0010_0093` → `WB_read_o` pulse in cycle 1, `addr_out`=`0x3300_0040`, `WB_sel_o`=`F`, `f_ack_o` in cycle 6, `f_rdata_o`=`0x0010_0093`.
- Store `d_addr_i`=`0x0000_0500`, `d_wdata_i`=`0xCAFE_F00D`, `d_sel_i`=`3` → `WB_write_o` pulse, `WBData_out`=`0xCAFEF00D`, `WB_sel_o`=`3`, `d_ack_o` once; `d_rdata_o` unchanged.
- Both requests raised together from reset, held continuously → grants alternate fetch, data, fetch, data; no port is granted twice in a row.
- `WB_busy_i` never asserts, `TIMEOUT`=8 on a load → ack with `err_o`=1 in the same cycle, `d_rdata_o`=`0xDEADBEEF`, exactly 8 WAIT cycles.
- `rst` pulsed during WAIT → next cycle all outputs 0, no ack; a request issued afterwards completes normally.
- `f_req_i` dropped during WAIT → fetch still acks; a pending data request is granted in the cycle after DONE.
